// File: rtl/cr_bin2gray_cntr_if.sv
// Control and result bundle for the binary/Gray up-down counter.
// The master drives count/load controls; the slave returns binary, Gray and wrap.
interface cr_bin2gray_cntr_if #(
  parameter int unsigned pWidth = 4
);
  logic              en;
  logic              dn;
  logic              ld;
  logic [pWidth-1:0] d;
  logic [pWidth-1:0] b;
  logic [pWidth-1:0] g;
  logic              wrap;

  modport master (
    output en, dn, ld, d,
    input  b, g, wrap
  );

  modport slave (
    input  en, dn, ld, d,
    output b, g, wrap
  );
endinterface

// File: rtl/cr_bin2gray_cntr.sv
// Registered binary/Gray up-down counter with synchronous load.
// Binary and Gray are both flopped from the same next value so every Gray bit is a clean flop output.
module cr_bin2gray_cntr #(
  parameter int unsigned        pWidth    = 4,
  parameter logic [pWidth-1:0]  pResetVal = '0
) (
  input  logic                i_clk,
  input  logic                i_rst,
  cr_bin2gray_cntr_if.slave   bus
);

  localparam logic [pWidth-1:0] ONE      = pWidth'(1);
  localparam logic [pWidth-1:0] RST_GRAY = pResetVal ^ (pResetVal >> 1);

  logic [pWidth-1:0] r_b;
  logic [pWidth-1:0] r_g;
  logic              r_wrap;

  logic [pWidth-1:0] w_b_inc;
  logic [pWidth-1:0] w_b_dec;
  logic [pWidth-1:0] w_b_next;
  logic [pWidth-1:0] w_g_next;
  logic              w_wrap_next;

  assign w_b_inc = r_b + ONE;
  assign w_b_dec = r_b - ONE;

  // Load beats count; direction only matters when enabled.
  always_comb begin
    w_b_next    = r_b;
    w_wrap_next = 1'b0;
    if (bus.ld) begin
      w_b_next = bus.d;
    end else if (bus.en) begin
      if (bus.dn) begin
        w_b_next    = w_b_dec;
        w_wrap_next = (r_b == '0);
      end else begin
        w_b_next    = w_b_inc;
        w_wrap_next = (&r_b);
      end
    end
  end

  assign w_g_next = w_b_next ^ (w_b_next >> 1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_b    <= pResetVal;
      r_g    <= RST_GRAY;
      r_wrap <= 1'b0;
    end else begin
      r_b    <= w_b_next;
      r_g    <= w_g_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign bus.b    = r_b;
  assign bus.g    = r_g;
  assign bus.wrap = r_wrap;

endmodule

// File: doc/cr_bin2gray_cntr.md
# cr_bin2gray_cntr

Registered binary-to-Gray up/down counter with synchronous load. Maintains a binary count and its Gray-code equivalent in flops, both updated on the same edge, so the Gray output is glitch-free and changes by exactly one bit per count step. It is the encoding end of a Gray-coded pointer path: its Gray output is synchronised across a clock domain and decoded on the far side by cr_gray2bin. Primary use is async-FIFO read/write pointers and cross-domain position counters.

## Interface

- pWidth, 4, counter and datapath width; legal range 2..32
- pResetVal, 0, binary count value loaded on reset; must fit in pWidth bits

- Clk  input  1  clock; all state updates on rising edge
- Rst  input  1  reset, synchronous, active-high
- En  input  1  count enable; one step per cycle while high
- Dn  input  1  direction; 0 = increment, 1 = decrement; sampled only when En is high
- Ld  input  1  synchronous load strobe
- D  input  pWidth  binary load value
- B  output  pWidth  registered binary count
- G  output  pWidth  registered Gray code of B: G = B ^ (B >> 1)
- Wrap  output  1  registered one-cycle pulse: the last update wrapped the count

## Operation

- Priority on each rising edge: Rst > Ld > En > hold.
- Rst: B <= pResetVal; G <= gray(pResetVal); Wrap <= 0. Reset mid-count or mid-load aborts the operation. No partial update.
- Ld (Rst low): B <= D; G <= gray(D); Wrap <= 0. En and Dn are ignored in that cycle.
- En, Dn=0: B <= B + 1, modulo 2^pWidth. If B was all-ones, B becomes 0 and Wrap <= 1. Otherwise Wrap <= 0.
- En, Dn=1: B <= B - 1, modulo 2^pWidth. If B was 0, B becomes all-ones and Wrap <= 1. Otherwise Wrap <= 0.
- Hold (En, Ld, Rst all low): B and G keep their values; Wrap <= 0.
- G is derived from the next binary value (bnext ^ (bnext >> 1)) and registered directly. G is never produced by combinational logic after the B flop. Each G bit is a flop output, which is required for safe CDC sampling.
- Invariant on every cycle after reset: G == B ^ (B >> 1).
- Single-bit-change guarantee: on any count step, including wrap in either direction, popcount(G_old ^ G_new) == 1.
  - The guarantee does not apply to load or reset steps.
  - Users must not load while a far-domain consumer depends on the guarantee.
- Direction reversal between consecutive enabled cycles is legal. The count steps back by one and the single-bit-change guarantee still holds.
- Wrap is exactly one cycle wide. Continuous counting across the boundary produces one pulse per wrap.

## Timing

- Latency: 1 cycle from sampled Rst/Ld/En to updated B, G and Wrap. Outputs are valid immediately after the edge.
- No combinational path from any input to any output.
- Throughput: one count step per cycle with En held high. For pWidth=4 that gives a full period of 16 cycles.
- Reset values: B = pResetVal, G = gray(pResetVal), Wrap = 0.
  - Rst must be held for at least 1 cycle.
  - Outputs before the first reset edge are undefined.
- Next-state logic depth: one pWidth-bit add/subtract plus one XOR level. Sizing targets a single-cycle path at pWidth=32.

## Test plan

- Reset: pWidth=4, pResetVal=5, Rst high for 2 cycles -> B=5, G=4'b0111, Wrap=0. Repeat with Rst asserted while En=1 and Ld=1 -> same values.
- Up-count full period: after reset to 0, En=1, Dn=0 for 16 cycles -> B steps 0..15 then 0. G steps 0000,0001,0011,0010,…,1000 then 0000. Wrap=1 only in the cycle B returns to 0. Every step has popcount(ΔG)=1.
- Down-count wrap: Ld with D=1, then En=1, Dn=1 for 3 cycles -> B = 0, 15, 14. G = 0000, 1000, 1001. Wrap=1 only on the 0->15 step.
- Priority and hold: B=7 with Ld=1, D=12, En=1 -> B=12, G=1010, Wrap=0. Then all inputs low for 3 cycles -> B=12 held, Wrap=0. Then Rst=1 with Ld=1 -> B=pResetVal.
- Direction reversal: at B=9, En=1 with Dn pattern 0,1,1,0 -> B = 10, 9, 8, 9. Each G step changes exactly 1 bit. Wrap stays 0.
- Random regression: pWidth in {2, 8, 32}, 10k cycles of random En/Dn/Ld/D -> check G == B^(B>>1) every cycle, B against a reference model, popcount(ΔG)=1 on all count steps, and Wrap against the model.
